// File: rtl/projectile_motion_engine_if.sv
// Game-manager / sprite-drawer side of the projectile engine; wind exists only with PME_WIND_EN.
interface projectile_motion_engine_if #(
  parameter int W = 11
);
  logic                start_of_frame;
  logic                launch_valid;
  logic                launch_ready;
  logic signed [W-1:0] launch_x;
  logic signed [W-1:0] launch_y;
  logic signed [15:0]  launch_vx;
  logic signed [15:0]  launch_vy;
  logic                abort;
  logic                collision;
  logic [3:0]          hit_edges;
  logic signed [W-1:0] top_left_x;
  logic signed [W-1:0] top_left_y;
  logic                active;
  logic                done_pulse;
  logic [15:0]         speed_sum;
`ifdef PME_WIND_EN
  logic signed [7:0]   wind;
`endif

  modport master (
`ifdef PME_WIND_EN
    output wind,
`endif
    output start_of_frame, launch_valid, launch_x, launch_y, launch_vx, launch_vy,
    output abort, collision, hit_edges,
    input  launch_ready, top_left_x, top_left_y, active, done_pulse, speed_sum
  );

  modport slave (
`ifdef PME_WIND_EN
    input  wind,
`endif
    input  start_of_frame, launch_valid, launch_x, launch_y, launch_vx, launch_vy,
    input  abort, collision, hit_edges,
    output launch_ready, top_left_x, top_left_y, active, done_pulse, speed_sum
  );
endinterface

// File: rtl/projectile_motion_engine.sv
// Fixed-point sprite projectile: per-frame bounce/integrate/clamp, new top_left 3 clk after SOF;
// launch accepted only in IDLE, retires after REST_FRAMES slow grounded frames or abort. PME_WIND_EN adds crosswind.
module projectile_motion_engine #(
  parameter int W           = 11,
  parameter int FP_SHIFT    = 6,
  parameter int GRAVITY     = 10,
  parameter int MAX_VY      = 500,
  parameter int LOSS_SHIFT  = 1,
  parameter int OBJ_W       = 64,
  parameter int OBJ_H       = 64,
  parameter int MARGIN      = 2,
  parameter int SCR_W       = 640,
  parameter int SCR_H       = 480,
  parameter int REST_THRESH = 10,
  parameter int REST_FRAMES = 3
) (
  input logic                        clk,
  input logic                        reset,
  projectile_motion_engine_if.slave  bus
);

  localparam int X_MIN = MARGIN * (2 ** FP_SHIFT);
  localparam int Y_MIN = MARGIN * (2 ** FP_SHIFT);
  localparam int X_MAX = (SCR_W - 1 - MARGIN - OBJ_W) * (2 ** FP_SHIFT);
  localparam int Y_MAX = (SCR_H - 1 - MARGIN - OBJ_H) * (2 ** FP_SHIFT);

  typedef enum logic [2:0] {IDLE, FLIGHT, RESOLVE, INTEGRATE, LIMIT, DONE} state_t;

  state_t              state, state_next;
  logic signed [31:0]  pos_x, pos_y, vx, vy;
  logic [3:0]          hit_acc;
  logic                grounded;
  logic [7:0]          rest_cnt;
  logic                active_q;
  logic [15:0]         speed_q;

  logic [3:0]          hit_in;
  logic                x_opp, y_opp, x_bnc, y_bnc;
  logic signed [31:0]  vx_ref, vy_ref, vx_res, vy_res, vx_lim, vy_lim;
  logic                x_lo, x_hi, y_lo, y_hi;
  logic [31:0]         ax, ay;
  logic [32:0]         spd_full;
  logic [15:0]         spd_sat;
  logic                slow;
  logic [7:0]          rest_next;
  logic                abort_hit;

  // Shift toward zero: plain >>> would round negative speeds away from zero.
  function automatic logic signed [31:0] lossy(input logic signed [31:0] v);
    return v[31] ? -((-v) >>> LOSS_SHIFT) : (v >>> LOSS_SHIFT);
  endfunction

  function automatic logic signed [31:0] sat_v(input logic signed [31:0] v);
    if (v > MAX_VY)  return MAX_VY;
    if (v < -MAX_VY) return -MAX_VY;
    return v;
  endfunction

  function automatic logic [31:0] abs_v(input logic signed [31:0] v);
    return v[31] ? $unsigned(-v) : $unsigned(v);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    hit_in    = bus.collision ? bus.hit_edges : 4'b0000;
    abort_hit = bus.abort && (state != IDLE) && (state != DONE);

    // hit_acc bits: [3]=left [2]=top [1]=right [0]=bottom
    y_opp  = hit_acc[2] && hit_acc[0];
    x_opp  = hit_acc[3] && hit_acc[1];
    y_bnc  = !y_opp && ((hit_acc[0] && vy > 0) || (hit_acc[2] && vy < 0));
    x_bnc  = !x_opp && ((hit_acc[3] && vx < 0) || (hit_acc[1] && vx > 0));
    vx_ref = (x_opp || x_bnc) ? -vx : vx;
    vy_ref = (y_opp || y_bnc) ? -vy : vy;
    vx_res = (x_bnc || y_bnc) ? lossy(vx_ref) : vx_ref;
    vy_res = (x_bnc || y_bnc) ? lossy(vy_ref) : vy_ref;

    x_lo   = pos_x < X_MIN;
    x_hi   = pos_x > X_MAX;
    y_lo   = pos_y < Y_MIN;
    y_hi   = pos_y > Y_MAX;
    vx_lim = (x_lo || x_hi) ? 32'sd0 : vx;
    vy_lim = (y_lo || y_hi) ? 32'sd0 : vy;
    ax       = abs_v(vx_lim);
    ay       = abs_v(vy_lim);
    spd_full = {1'b0, ax} + {1'b0, ay};
    spd_sat  = (|spd_full[32:16]) ? 16'hFFFF : spd_full[15:0];
    slow      = grounded && (ax <= $unsigned(REST_THRESH)) && (ay <= $unsigned(REST_THRESH));
    rest_next = slow ? rest_cnt + 8'd1 : 8'd0;

    state_next = state;
    case (state)
      IDLE:      if (bus.launch_valid) state_next = FLIGHT;
      FLIGHT:    if (bus.start_of_frame) state_next = RESOLVE;
      RESOLVE:   state_next = INTEGRATE;
      INTEGRATE: state_next = LIMIT;
      LIMIT:     state_next = (rest_next >= 8'(REST_FRAMES)) ? DONE : FLIGHT;
      DONE:      state_next = IDLE;
      default:   state_next = IDLE;
    endcase
    if (abort_hit) state_next = DONE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pos_x    <= '0;
      pos_y    <= '0;
      vx       <= '0;
      vy       <= '0;
      hit_acc  <= '0;
      grounded <= 1'b0;
      rest_cnt <= '0;
      active_q <= 1'b0;
      speed_q  <= '0;
    end else if (!abort_hit) begin
      case (state)
        IDLE: if (bus.launch_valid) begin
          pos_x    <= 32'(bus.launch_x) <<< FP_SHIFT;
          pos_y    <= 32'(bus.launch_y) <<< FP_SHIFT;
          vx       <= 32'(bus.launch_vx);
          vy       <= 32'(bus.launch_vy);
          hit_acc  <= '0;
          grounded <= 1'b0;
          rest_cnt <= '0;
          active_q <= 1'b1;
        end
        FLIGHT: hit_acc <= hit_acc | hit_in;
        RESOLVE: begin
          vx       <= vx_res;
          vy       <= vy_res;
          grounded <= hit_acc[0];
          hit_acc  <= hit_in;
        end
        INTEGRATE: begin
          pos_x   <= pos_x + vx;
          pos_y   <= pos_y + vy;
          vy      <= sat_v(vy + GRAVITY);
`ifdef PME_WIND_EN
          vx      <= sat_v(vx + 32'(bus.wind));
`endif
          hit_acc <= hit_acc | hit_in;
        end
        LIMIT: begin
          pos_x    <= x_lo ? X_MIN : (x_hi ? X_MAX : pos_x);
          pos_y    <= y_lo ? Y_MIN : (y_hi ? Y_MAX : pos_y);
          vx       <= vx_lim;
          vy       <= vy_lim;
          speed_q  <= spd_sat;
          rest_cnt <= rest_next;
          hit_acc  <= hit_acc | hit_in;
        end
        DONE: active_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.launch_ready = (state == IDLE);
  assign bus.done_pulse   = (state == DONE);
  assign bus.active       = active_q;
  assign bus.speed_sum    = speed_q;
  assign bus.top_left_x   = W'(pos_x >>> FP_SHIFT);
  assign bus.top_left_y   = W'(pos_y >>> FP_SHIFT);

endmodule

// File: tb/tb_projectile_motion_engine.sv
// Directed bench for projectile_motion_engine with a frame-level reference model.
module tb_projectile_motion_engine;

  logic clk;
  logic reset;
  projectile_motion_engine_if #(.W(11)) bus ();

  projectile_motion_engine dut (.clk(clk), .reset(reset), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: internal fixed-point units, 64 per pixel.
  int m_x, m_y, m_vx, m_vy, m_rest, m_speed;
  logic [3:0] m_acc;
  bit m_done;
  bit exp_active, exp_ready, cmp_en;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  function automatic int absi(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic model_launch(input int x, input int y, input int vx0, input int vy0);
    m_x = x * 64; m_y = y * 64; m_vx = vx0; m_vy = vy0;
    m_rest = 0; m_acc = 4'b0; m_done = 0;
    exp_active = 1; exp_ready = 0;
  endtask

  task automatic model_frame(input logic [3:0] h);
    bit l, t, r, b, ybounce, xbounce;
    l = h[3]; t = h[2]; r = h[1]; b = h[0];
    ybounce = !(t && b) && ((b && m_vy > 0) || (t && m_vy < 0));
    xbounce = !(l && r) && ((l && m_vx < 0) || (r && m_vx > 0));
    if ((t && b) || ybounce) m_vy = -m_vy;
    if ((l && r) || xbounce) m_vx = -m_vx;
    if (ybounce || xbounce) begin
      m_vx = m_vx / 2;   // integer division truncates toward zero
      m_vy = m_vy / 2;
    end
    m_x  = m_x + m_vx;
    m_y  = m_y + m_vy;
    m_vy = clampi(m_vy + 10, -500, 500);
    if (m_x < 2 * 64 || m_x > 573 * 64) begin m_x = clampi(m_x, 2 * 64, 573 * 64); m_vx = 0; end
    if (m_y < 2 * 64 || m_y > 413 * 64) begin m_y = clampi(m_y, 2 * 64, 413 * 64); m_vy = 0; end
    m_speed = absi(m_vx) + absi(m_vy);
    if (m_speed > 65535) m_speed = 65535;
    if (b && absi(m_vx) <= 10 && absi(m_vy) <= 10) m_rest++;
    else m_rest = 0;
    m_done = (m_rest >= 3);
  endtask

  // Continuous comparison whenever the engine is between frames.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc_tl_x", int'($signed(bus.top_left_x)), m_x >>> 6);
      chk("cyc_tl_y", int'($signed(bus.top_left_y)), m_y >>> 6);
      chk("cyc_active", int'(bus.active), int'(exp_active));
      chk("cyc_ready", int'(bus.launch_ready), int'(exp_ready));
      chk("cyc_done", int'(bus.done_pulse), 0);
      chk("cyc_speed", int'(bus.speed_sum), m_speed);
    end
  end

  task automatic launch(input int x, input int y, input int vx0, input int vy0);
    bus.launch_valid = 1'b1;
    bus.launch_x = 11'(x); bus.launch_y = 11'(y);
    bus.launch_vx = 16'(vx0); bus.launch_vy = 16'(vy0);
    @(posedge clk); #1;
    bus.launch_valid = 1'b0;
    model_launch(x, y, vx0, vy0);
    chk("launch_ready", int'(bus.launch_ready), 0);
    chk("launch_active", int'(bus.active), 1);
    chk("launch_tl_x", int'($signed(bus.top_left_x)), x);
    cmp_en = 1;
  endtask

  task automatic hit(input logic [3:0] h);
    bus.collision = 1'b1; bus.hit_edges = h;
    @(posedge clk); #1;
    bus.collision = 1'b0; bus.hit_edges = 4'b0;
    m_acc = m_acc | h;
  endtask

  task automatic frame(input logic [3:0] h);
    cmp_en = 0;
    bus.start_of_frame = 1'b1;
    bus.collision = (h != 4'b0);
    bus.hit_edges = h;
    @(posedge clk); #1;
    bus.start_of_frame = 1'b0; bus.collision = 1'b0; bus.hit_edges = 4'b0;
    repeat (3) @(posedge clk);
    #1;
    model_frame(m_acc | h);
    m_acc = 4'b0;
    chk("frm_done", int'(bus.done_pulse), int'(m_done));
    chk("frm_tl_x", int'($signed(bus.top_left_x)), m_x >>> 6);
    chk("frm_tl_y", int'($signed(bus.top_left_y)), m_y >>> 6);
    chk("frm_speed", int'(bus.speed_sum), m_speed);
    if (m_done) begin
      @(posedge clk); #1;
      exp_active = 0; exp_ready = 1;
      chk("post_done_pulse", int'(bus.done_pulse), 0);
      chk("post_done_active", int'(bus.active), 0);
      chk("post_done_ready", int'(bus.launch_ready), 1);
    end
    cmp_en = 1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int max_spd;
    bit saw_clamp;
    cmp_en = 0;
    reset = 1'b1;
    bus.start_of_frame = 0; bus.launch_valid = 0; bus.abort = 0; bus.collision = 0;
    bus.hit_edges = 0; bus.launch_x = 0; bus.launch_y = 0; bus.launch_vx = 0; bus.launch_vy = 0;
`ifdef PME_WIND_EN
    bus.wind = 0;
`endif
    m_x = 0; m_y = 0; m_vx = 0; m_vy = 0; m_rest = 0; m_speed = 0; m_acc = 0; m_done = 0;
    exp_active = 0; exp_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("rst_ready", int'(bus.launch_ready), 1);
    chk("rst_active", int'(bus.active), 0);
    chk("rst_done", int'(bus.done_pulse), 0);
    chk("rst_speed", int'(bus.speed_sum), 0);
    chk("rst_tl_y", int'($signed(bus.top_left_y)), 0);
    cmp_en = 1;

    // 1: first frame of a horizontal launch
    launch(100, 100, 64, 0);
    frame(4'b0000);
    chk("t1_x_lit", int'($signed(bus.top_left_x)), 101);
    chk("t1_y_lit", int'($signed(bus.top_left_y)), 100);
    chk("t1_speed_lit", int'(bus.speed_sum), 74);

    // 2: free fall to saturation and floor clamp
    max_spd = 0; saw_clamp = 0;
    for (int i = 0; i < 70; i++) begin
      frame(4'b0000);
      if (int'(bus.speed_sum) > max_spd) max_spd = int'(bus.speed_sum);
      if (bus.speed_sum == 16'd64 && bus.top_left_y == 11'sd413) saw_clamp = 1;
    end
    chk("t2_vy_sat_lit", max_spd, 564);
    chk("t2_y_clamp_lit", int'($signed(bus.top_left_y)), 413);
    chk("t2_vy_zeroed_lit", int'(saw_clamp), 1);

    // abort to get back to IDLE
    cmp_en = 0;
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    chk("t2_abort_done", int'(bus.done_pulse), 1);
    @(posedge clk); #1;
    exp_active = 0; exp_ready = 1;
    cmp_en = 1;

    // 3: bottom bounce, hit in a separate cycle before SOF
    launch(100, 100, 64, 200);
    hit(4'b0001);
    frame(4'b0000);
    chk("t3_y_lit", int'($signed(bus.top_left_y)), 98);
    chk("t3_x_lit", int'($signed(bus.top_left_x)), 100);
    chk("t3_speed_lit", int'(bus.speed_sum), 122);
    cmp_en = 0;
    bus.abort = 1'b1; @(posedge clk); #1; bus.abort = 1'b0;
    @(posedge clk); #1;
    exp_active = 0; exp_ready = 1; cmp_en = 1;

    // 4: top-right corner, truncation toward zero on both signs
    launch(200, 200, 9, -7);
    frame(4'b0110);
    chk("t4_x_lit", int'($signed(bus.top_left_x)), 199);
    chk("t4_y_lit", int'($signed(bus.top_left_y)), 200);
    chk("t4_speed_lit", int'(bus.speed_sum), 17);
    cmp_en = 0;
    bus.abort = 1'b1; @(posedge clk); #1; bus.abort = 1'b0;
    @(posedge clk); #1;
    exp_active = 0; exp_ready = 1; cmp_en = 1;

    // 5a: three slow grounded frames retire the object
    launch(100, 100, 0, 0);
    frame(4'b0001);
    frame(4'b0001);
    frame(4'b0001);
    chk("t5_retired_lit", int'(bus.active), 0);

    // 5b: a fast ungrounded frame resets the rest count
    launch(100, 100, 0, 0);
    frame(4'b0001);
    frame(4'b0001);
    frame(4'b0000);
    frame(4'b0001);
    frame(4'b0001);
    chk("t5b_no_retire_lit", int'(bus.active), 1);
    frame(4'b0001);
    chk("t5b_retired_lit", int'(bus.active), 0);

    // 6: abort in FLIGHT with launch_valid held -> relaunch one cycle after DONE
    launch(300, 200, 0, 0);
    cmp_en = 0;
    bus.abort = 1'b1;
    bus.launch_valid = 1'b1;
    bus.launch_x = 11'sd50; bus.launch_y = 11'sd60; bus.launch_vx = 16'sd0; bus.launch_vy = 16'sd0;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    chk("t6_abort_done", int'(bus.done_pulse), 1);
    chk("t6_abort_ready", int'(bus.launch_ready), 0);
    @(posedge clk); #1;
    chk("t6_idle_ready", int'(bus.launch_ready), 1);
    chk("t6_idle_active", int'(bus.active), 0);
    chk("t6_idle_done", int'(bus.done_pulse), 0);
    @(posedge clk); #1;
    bus.launch_valid = 1'b0;
    model_launch(50, 60, 0, 0);
    chk("t6_relaunch_ready", int'(bus.launch_ready), 0);
    chk("t6_relaunch_active", int'(bus.active), 1);
    chk("t6_relaunch_x", int'($signed(bus.top_left_x)), 50);
    cmp_en = 1;

    // abort during RESOLVE: no integration happens
    cmp_en = 0;
    bus.start_of_frame = 1'b1;
    @(posedge clk); #1;
    bus.start_of_frame = 1'b0;
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    chk("t6_res_abort_done", int'(bus.done_pulse), 1);
    chk("t6_res_abort_y", int'($signed(bus.top_left_y)), 60);
    @(posedge clk); #1;
    exp_active = 0; exp_ready = 1;
    cmp_en = 1;

    // abort in IDLE is ignored
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    chk("idle_abort_done", int'(bus.done_pulse), 0);
    chk("idle_abort_ready", int'(bus.launch_ready), 1);

    // reset mid-flight
    launch(150, 150, 20, 0);
    frame(4'b0000);
    cmp_en = 0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midrst_active", int'(bus.active), 0);
    chk("midrst_done", int'(bus.done_pulse), 0);
    chk("midrst_speed", int'(bus.speed_sum), 0);
    chk("midrst_ready", int'(bus.launch_ready), 1);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
